bf16_dot_sequencer: RTL and testbench



---
 rtl/bf16_dot_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bf16_dot_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bf16_dot_sequencer.sv
// bf16_dot_sequencer: streams len operand pairs through a bfloat16 fused MAC into a seeded accumulator.
// Optional BF16_DOT_ABORT_EN adds an abort input that drops the running job.
module mac_bfloat16 #(
  parameter int N_SIG = 7,
  parameter int N_EXP = 8,
  parameter int N_DATA = N_EXP + N_SIG + 1
) (
  input  logic [N_DATA-1:0] a,
  input  logic [N_DATA-1:0] b,
  input  logic [N_DATA-1:0] c,
  input  logic [2:0]        rnd,
  output logic [N_DATA-1:0] z,
  output logic [7:0]        status
);
  localparam int WM = 2 * N_SIG + 2;
  localparam int W = 2 * WM;
  localparam int ONE = 2 * N_SIG + WM;
  localparam int EW = N_EXP + 3;
  localparam int BIAS = (1 << (N_EXP - 1)) - 1;
  localparam logic [N_EXP-1:0] EMAX = '1;
  localparam logic [N_EXP-1:0] EMAX_M1 = EMAX - 1'b1;
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << N_EXP) - 1);
  // right shift that folds every lost bit into the lsb as a sticky bit
  function automatic logic [W-1:0] shr(input logic [W-1:0] v, input logic signed [EW-1:0] d);
    logic [W-1:0] m;
    if (int'(d) >= W) return {{(W-1){1'b0}}, |v};
    m = ~({W{1'b1}} << d);
    return (v >> d) | {{(W-1){1'b0}}, |(v & m)};
  endfunction
  logic sa, sb, sc, sp, sr, pz, cz, sub, g, st, inc, toinf;
  logic a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, p_inf, nan;
  logic [N_EXP-1:0] ea, eb, ec;
  logic [N_SIG-1:0] fa, fb, fc;
  logic [WM-1:0] mp;
  logic [W-1:0] pf, cf;
  logic [W:0] s, sn;
  logic [N_SIG+1:0] mr;
  logic signed [EW-1:0] ep, ecs, emx, er, ern;
  int lz;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign {sc, ec, fc} = c;
  assign a_nan = ea == EMAX && |fa;
  assign b_nan = eb == EMAX && |fb;
  assign c_nan = ec == EMAX && |fc;
  assign a_inf = ea == EMAX && !(|fa);
  assign b_inf = eb == EMAX && !(|fb);
  assign c_inf = ec == EMAX && !(|fc);
  assign p_inf = a_inf | b_inf;
  assign sp = sa ^ sb;
  assign sub = sp ^ sc;
  // subnormal operands are treated as zero
  assign pz = ea == '0 || eb == '0;
  assign cz = ec == '0;
  assign nan = a_nan | b_nan | c_nan | (a_inf & eb == '0) | (b_inf & ea == '0) | (p_inf & c_inf & sub);
  always_comb begin
    mp = WM'({1'b1, fa}) * WM'({1'b1, fb});
    ep = EW'(ea) + EW'(eb) - EW'(BIAS);
    ecs = EW'(ec);
    emx = pz ? ecs : cz ? ep : (ecs > ep ? ecs : ep);
    pf = pz ? '0 : shr({mp, {WM{1'b0}}}, emx - ep);
    cf = cz ? '0 : shr({1'b0, 1'b1, fc, {N_SIG{1'b0}}, {WM{1'b0}}}, emx - ecs);
    s = !sub ? {1'b0, pf} + {1'b0, cf} : (cf > pf ? {1'b0, cf - pf} : {1'b0, pf - cf});
    sr = (sub && cf > pf) ? sc : sp;
    lz = 0;
    for (int i = 0; i <= W; i++) if (s[i]) lz = i;
    sn = s << (W - lz);
    er = emx + EW'(lz - ONE);
    g = sn[W-N_SIG-1];
    st = |sn[W-N_SIG-2:0];
    inc = rnd == 3'd1 ? 1'b0 : rnd == 3'd2 ? !sr & (g | st) : rnd == 3'd3 ? sr & (g | st) :
          rnd == 3'd4 ? g : rnd == 3'd5 ? g | st : g & (st | sn[W-N_SIG]);
    mr = {1'b0, sn[W -: N_SIG+1]} + (N_SIG+2)'(inc);
    ern = er + EW'(mr[N_SIG+1]);
    toinf = !(rnd == 3'd1 || (rnd == 3'd2 && sr) || (rnd == 3'd3 && !sr));
    z = '0;
    status = '0;
    if (nan) begin
      z = {1'b0, EMAX, 1'b1, {(N_SIG-1){1'b0}}};
      status[2] = 1'b1;
    end else if (p_inf | c_inf) begin
      z = {p_inf ? sp : sc, EMAX, {N_SIG{1'b0}}};
      status[1] = 1'b1;
    end else if (s == '0) begin
      z = {(sp == sc) ? sp : (rnd == 3'd3), {(N_DATA-1){1'b0}}};
      status[0] = 1'b1;
    end else if (er[EW-1] || er == '0) begin
      z = {sr, {(N_DATA-1){1'b0}}};
      status[0] = 1'b1;
      status[3] = 1'b1;
      status[5] = 1'b1;
    end else if (ern >= EMAX_S) begin
      z = toinf ? {sr, EMAX, {N_SIG{1'b0}}} : {sr, EMAX_M1, {N_SIG{1'b1}}};
      status[1] = toinf;
      status[4] = 1'b1;
      status[5] = 1'b1;
    end else begin
      z = {sr, ern[N_EXP-1:0], mr[N_SIG-1:0]};
      status[5] = g | st;
    end
  end
endmodule

module bf16_dot_sequencer #(
  parameter int N_SIG = 7,
  parameter int N_EXP = 8,
  parameter int N_DATA = N_EXP + N_SIG + 1,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [N_DATA-1:0] init,
  input  logic [2:0]        rnd,
`ifdef BF16_DOT_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_DATA-1:0] in_a,
  input  logic [N_DATA-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_DATA-1:0] out_z,
  output logic [7:0]        out_status,
  output logic [LEN_W-1:0]  out_count
);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [N_DATA-1:0] acc, mz;
  logic [7:0] sts, ms;
  logic [LEN_W-1:0] cnt, beats;
  logic [2:0] rnd_q;
  logic ab, fire;
`ifdef BF16_DOT_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  mac_bfloat16 #(.N_SIG(N_SIG), .N_EXP(N_EXP), .N_DATA(N_DATA)) mac (
    .a(in_a), .b(in_b), .c(acc), .rnd(rnd_q), .z(mz), .status(ms)
  );
  assign busy = state != IDLE;
  assign in_ready = state == ACCUM && !ab;
  assign fire = in_valid & in_ready;
  assign out_valid = state == DONE;
  assign out_z = acc;
  assign out_status = sts;
  assign out_count = beats;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      sts <= '0;
      cnt <= '0;
      beats <= '0;
      rnd_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= init;
          cnt <= len;
          beats <= '0;
          sts <= '0;
          rnd_q <= rnd;
          state <= len == '0 ? DONE : ACCUM;
        end
        ACCUM: if (ab) state <= IDLE;
        else if (fire) begin
          acc <= mz;
          sts <= sts | ms;
          cnt <= cnt - 1'b1;
          beats <= beats + 1'b1;
          if (cnt == LEN_W'(1)) state <= DONE;
        end
        DONE: if (ab || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf16_dot_sequencer.sv
// tb_bf16_dot_sequencer: directed scenarios with hand-computed bfloat16 results.
module tb_bf16_dot_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] len = '0;
  logic [15:0] init = '0, in_a = '0, in_b = '0;
  logic [2:0] rnd = '0;
  logic busy, in_ready, out_valid;
  logic [15:0] out_z;
  logic [7:0] out_status, out_count;
`ifdef BF16_DOT_ABORT_EN
  logic abort = 1'b0;
`endif
  int pass_n = 0, total_n = 0;

  bf16_dot_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .init(init), .rnd(rnd),
`ifdef BF16_DOT_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_status(out_status), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] l, input logic [15:0] i);
    start = 1'b1;
    len = l;
    init = i;
    rnd = 3'd0;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total_n++; if ({busy, in_ready, out_valid} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {busy, in_ready, out_valid}); else pass_n++;
    total_n++; if (out_z !== 16'h0000) $display("FAIL reset_z: got %h expected 0000", out_z); else pass_n++;
    total_n++; if ({out_status, out_count} !== 16'h0000) $display("FAIL reset_sts_cnt: got %h expected 0000", {out_status, out_count}); else pass_n++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_dot();
    start_job(8'd3, 16'h0000);
    total_n++; if (in_ready !== 1'b1) $display("FAIL dot_ready: got %b expected 1", in_ready); else pass_n++;
    beat(16'h3F80, 16'h4000);
    beat(16'h4000, 16'h4000);
    total_n++; if (out_valid !== 1'b0) $display("FAIL dot_early_valid: got %b expected 0", out_valid); else pass_n++;
    beat(16'h4040, 16'h4000);
    total_n++; if (out_valid !== 1'b1) $display("FAIL dot_valid: got %b expected 1", out_valid); else pass_n++;
    total_n++; if (out_z !== 16'h4140) $display("FAIL dot_z: got %h expected 4140", out_z); else pass_n++;
    total_n++; if (out_count !== 8'd3) $display("FAIL dot_count: got %0d expected 3", out_count); else pass_n++;
    total_n++; if (out_status !== 8'h00) $display("FAIL dot_status: got %h expected 00", out_status); else pass_n++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_n++; if ({busy, out_valid} !== 2'b00) $display("FAIL dot_release: got %b expected 00", {busy, out_valid}); else pass_n++;
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 8'd0; init = 16'h3F80;
    #1;
    total_n++; if (in_ready !== 1'b0) $display("FAIL zl_ready_idle: got %b expected 0", in_ready); else pass_n++;
    step();
    start = 1'b0;
    total_n++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL zl_valid_ready: got %b expected 10", {out_valid, in_ready}); else pass_n++;
    total_n++; if (out_z !== 16'h3F80) $display("FAIL zl_z: got %h expected 3f80", out_z); else pass_n++;
    total_n++; if ({out_status, out_count} !== 16'h0000) $display("FAIL zl_sts_cnt: got %h expected 0000", {out_status, out_count}); else pass_n++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_n++; if (out_valid !== 1'b0) $display("FAIL zl_drop: got %b expected 0", out_valid); else pass_n++;
  endtask

  task automatic test_bubbles();
    start_job(8'd2, 16'h0000);
    beat(16'h3F00, 16'h4000);
    for (int i = 0; i < 3; i++) begin
      step();
      total_n++; if ({busy, in_ready, out_valid} !== 3'b110) $display("FAIL bub_idle%0d: got %b expected 110", i, {busy, in_ready, out_valid}); else pass_n++;
    end
    beat(16'h3F80, 16'h3F80);
    total_n++; if (out_z !== 16'h4000) $display("FAIL bub_z: got %h expected 4000", out_z); else pass_n++;
    total_n++; if (out_count !== 8'd2) $display("FAIL bub_count: got %0d expected 2", out_count); else pass_n++;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len = 8'd1;
      init = 16'h1234;
      step();
      start = 1'b0;
      total_n++; if ({busy, out_valid, out_z, out_count} !== {2'b11, 16'h4000, 8'd2}) $display("FAIL stall%0d: got %b %h %0d expected 11 4000 2", i, {busy, out_valid}, out_z, out_count); else pass_n++;
    end
    out_ready = 1'b1;
    start = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    total_n++; if ({busy, out_valid} !== 2'b00) $display("FAIL handshake_start: got %b expected 00", {busy, out_valid}); else pass_n++;
    step();
    total_n++; if (busy !== 1'b0) $display("FAIL handshake_start_idle: got %b expected 0", busy); else pass_n++;
  endtask

  task automatic test_sticky();
    start_job(8'd2, 16'h0000);
    beat(16'h7F7F, 16'h4000);
    beat(16'h0000, 16'h3F80);
    total_n++; if (out_z !== 16'h7F80) $display("FAIL sticky_z: got %h expected 7f80", out_z); else pass_n++;
    total_n++; if ((out_status & 8'h12) !== 8'h12) $display("FAIL sticky_status: got %h expected bits 1,4 set", out_status); else pass_n++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_job(8'd4, 16'h0000);
    beat(16'h3F80, 16'h3F80);
    beat(16'h3F80, 16'h3F80);
    in_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    total_n++; if ({busy, in_ready, out_valid, out_z, out_status, out_count} !== 35'd0) $display("FAIL mid_reset: got %h expected 0", {busy, in_ready, out_valid, out_z, out_status, out_count}); else pass_n++;
    start_job(8'd1, 16'h0000);
    beat(16'h3F80, 16'h3F80);
    total_n++; if ({out_valid, out_z} !== {1'b1, 16'h3F80}) $display("FAIL fresh_z: got %b %h expected 1 3f80", out_valid, out_z); else pass_n++;
    total_n++; if ({out_status, out_count} !== {8'h00, 8'd1}) $display("FAIL fresh_sts_cnt: got %h %0d expected 00 1", out_status, out_count); else pass_n++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_max_len();
    start_job(8'd255, 16'h0000);
    for (int i = 0; i < 255; i++) beat(16'h0000, 16'h0000);
    total_n++; if ({out_valid, out_count} !== {1'b1, 8'd255}) $display("FAIL maxlen_count: got %b %0d expected 1 255", out_valid, out_count); else pass_n++;
    total_n++; if ({out_z, out_status} !== {16'h0000, 8'h01}) $display("FAIL maxlen_z_sts: got %h %h expected 0000 01", out_z, out_status); else pass_n++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    start_job(8'd4, 16'h0000);
    beat(16'h3F80, 16'h3F80);
`ifdef BF16_DOT_ABORT_EN
    in_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h3F80; abort = 1'b1;
    #1;
    total_n++; if (in_ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", in_ready); else pass_n++;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    total_n++; if ({busy, out_valid} !== 2'b00) $display("FAIL abort_idle: got %b expected 00", {busy, out_valid}); else pass_n++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_n++; if (out_valid !== 1'b0) $display("FAIL abort_no_out%0d: got %b expected 0", i, out_valid); else pass_n++;
    end
`else
    beat(16'h3F80, 16'h3F80);
    beat(16'h3F80, 16'h3F80);
    beat(16'h3F80, 16'h3F80);
    total_n++; if ({out_valid, out_z, out_count} !== {1'b1, 16'h4080, 8'd4}) $display("FAIL noabort_done: got %b %h %0d expected 1 4080 4", out_valid, out_z, out_count); else pass_n++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_n++; if (busy !== 1'b0) $display("FAIL noabort_idle: got %b expected 0", busy); else pass_n++;
`endif
  endtask

  initial begin
    test_reset();
    test_dot();
    test_zero_len();
    test_bubbles();
    test_sticky();
    test_reset_mid();
    test_max_len();
    test_abort();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
